traffic_fsm: RTL and testbench
==============================

# traffic_fsm

Moore state machine that sequences the main-street and side-street lights and the pedestrian walk lamp. It sits directly upstream of the countdown timer. On every state entry it issues a one-cycle `start_timer` pulse plus an interval select for the time-parameter block, then holds its state until the timer returns a one-cycle `expired` pulse. The vehicle sensor and a latched walk request steer the branch decisions.

## Interface
Parameters: none. Interval encodings are fixed: 2'b00 = tBASE, 2'b01 = tEXT, 2'b10 = tYEL, 2'b11 unused.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_global  in  1  asynchronous, active-low reset
- reprogram  in  1  synchronous restart of the light sequence; active-high
- sensor  in  1  side-street vehicle present; synchronous level
- walk_request  in  1  pedestrian button; synchronous, debounced upstream
- expired  in  1  one-cycle pulse from the timer
- start_timer  out  1  one-cycle pulse; timer loads the selected interval
- interval_sel  out  2  interval for the current state; drives the time-parameter block
- main_light  out  3  {red, yellow, green}, one-hot
- side_light  out  3  {red, yellow, green}, one-hot
- walk_light  out  1  walk lamp

## Operation
States, with interval and lights (main/side):
- INIT: no interval; R/R
- MAIN_GRN1: tBASE; G/R
- MAIN_GRN2: tEXT if `sensor`=1 on entry, else tBASE; G/R
- MAIN_YEL: tYEL; Y/R
- WALK: tEXT; R/R, `walk_light`=1
- SIDE_GRN: tBASE; R/G
- SIDE_EXT: tEXT; R/G
- SIDE_YEL: tYEL; R/Y

Transitions:
- INIT always goes to MAIN_GRN1 on the next edge.
- MAIN_GRN1 goes to MAIN_GRN2 on `expired`.
- MAIN_GRN2 goes to MAIN_YEL on `expired`.
- MAIN_YEL on `expired`: goes to WALK if (`walk_pending` | `walk_request`), else SIDE_GRN.
- WALK goes to SIDE_GRN on `expired`.
- SIDE_GRN on `expired`: goes to SIDE_EXT if `sensor`=1 that cycle, else SIDE_YEL.
- SIDE_EXT goes to SIDE_YEL on `expired`.
- SIDE_YEL goes to MAIN_GRN1 on `expired`.

Outputs and registers:
- The MAIN_GRN2 interval is latched in a 1-bit register at entry. `interval_sel` is constant for the whole state.
- `walk_pending` is set by `walk_request` in any state except WALK. It is cleared on entry to WALK, and clear wins over set. Requests during WALK are discarded.
- Every transition, including INIT to MAIN_GRN1, asserts `start_timer` for exactly the first cycle in the new state. No pulse otherwise.
- Lights and `walk_light` are decoded from the state register only, so they are glitch-free. Exactly one bit of each light bus is high at all times.

Priority:
- `reprogram`=1 forces MAIN_GRN1 on the next edge, clears `walk_pending`, and pulses `start_timer`. This applies in every state, including MAIN_GRN1, where it restarts the interval.
- `reprogram` overrides `expired` arriving in the same cycle.
- `expired` in INIT, or in the same cycle that `start_timer` is high, is ignored.

## Timing
- `reset_global`=0: asynchronously forces INIT, `start_timer`=0, `interval_sel`=2'b00, `main_light`=`side_light`=3'b100, `walk_light`=0, `walk_pending`=0.
- First edge after deassertion: move to MAIN_GRN1, with `start_timer`=1 and `interval_sel`=00 in that same cycle.
- `expired` sampled high at edge N gives a new state, new lights, new `interval_sel` and `start_timer`=1 during cycle N+1. `start_timer` is low from N+2 onward.
- Decision inputs (`sensor`, `walk_request`) are sampled at the same edge as `expired`.
- Reset asserted mid-interval returns to INIT immediately. No stale `start_timer` pulse appears after release.

## Test plan
- Reset release with `sensor`=0: state INIT, then MAIN_GRN1. `start_timer` is high for 1 cycle with `interval_sel`=00, `main_light`=001, `side_light`=100.
- Full cycle with `sensor`=0 and no walk, driving `expired` once per state: `interval_sel` runs 00,00,10,00,10 and the light sequence is G, G, Y, side G, side Y, back to MAIN_GRN1. Exactly 6 `start_timer` pulses, counting the one at reset release.
- `sensor`=1 at MAIN_GRN2 entry: `interval_sel`=01. `sensor`=1 at SIDE_GRN `expired`: SIDE_EXT with `interval_sel`=01. Dropping `sensor` mid-state does not change `interval_sel`.
- `walk_request` pulsed in MAIN_GRN1: after MAIN_YEL `expired`, enter WALK with `walk_light`=1, both red, `interval_sel`=01. A second request during WALK does not cause WALK in the next cycle.
- `walk_request` coincident with MAIN_YEL `expired`: enters WALK.
- `reprogram` coincident with `expired` in SIDE_YEL, and asynchronous reset mid-MAIN_YEL: `reprogram` goes to MAIN_GRN1 with `start_timer` pulsed. The reset gives INIT outputs immediately, with no clock edge.

Source files
------------

// File: rtl/traffic_fsm_if.sv
// Signal bundle between the traffic light sequencer and its environment
// (countdown timer, time-parameter block, sensors, lamp drivers).
interface traffic_fsm_if;
  logic       reprogram;
  logic       sensor;
  logic       walk_request;
  logic       expired;
  logic       start_timer;
  logic [1:0] interval_sel;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_light;

  modport master (
    output reprogram, sensor, walk_request, expired,
    input  start_timer, interval_sel, main_light, side_light, walk_light
  );

  modport slave (
    input  reprogram, sensor, walk_request, expired,
    output start_timer, interval_sel, main_light, side_light, walk_light
  );
endinterface

// File: rtl/traffic_fsm.sv
// Moore sequencer for main/side street lights and pedestrian walk lamp.
// Pulses start_timer on every state entry and waits for the timer's expired pulse.
module traffic_fsm (
  input logic          clk,
  input logic          reset_global,
  traffic_fsm_if.slave bus
);

  localparam logic [2:0] INIT      = 3'd0;
  localparam logic [2:0] MAIN_GRN1 = 3'd1;
  localparam logic [2:0] MAIN_GRN2 = 3'd2;
  localparam logic [2:0] MAIN_YEL  = 3'd3;
  localparam logic [2:0] WALK      = 3'd4;
  localparam logic [2:0] SIDE_GRN  = 3'd5;
  localparam logic [2:0] SIDE_EXT  = 3'd6;
  localparam logic [2:0] SIDE_YEL  = 3'd7;

  localparam logic [1:0] T_BASE = 2'b00;
  localparam logic [1:0] T_EXT  = 2'b01;
  localparam logic [1:0] T_YEL  = 2'b10;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  logic [2:0] state;
  logic [2:0] next_state;
  logic       start_q;
  logic       walk_pending;
  logic       grn2_ext;
  logic       take;
  logic       enter;

  // expired is ignored while start_timer is high: the timer is just being loaded.
  always_comb begin
    next_state = state;
    take       = bus.expired && !start_q;
    if (bus.reprogram) begin
      next_state = MAIN_GRN1;
    end else if (state == INIT) begin
      next_state = MAIN_GRN1;
    end else if (take) begin
      case (state)
        MAIN_GRN1: next_state = MAIN_GRN2;
        MAIN_GRN2: next_state = MAIN_YEL;
        MAIN_YEL:  next_state = (walk_pending || bus.walk_request) ? WALK : SIDE_GRN;
        WALK:      next_state = SIDE_GRN;
        SIDE_GRN:  next_state = bus.sensor ? SIDE_EXT : SIDE_YEL;
        SIDE_EXT:  next_state = SIDE_YEL;
        SIDE_YEL:  next_state = MAIN_GRN1;
        default:   next_state = MAIN_GRN1;
      endcase
    end
  end

  // reprogram counts as an entry even when it re-enters MAIN_GRN1 from itself.
  assign enter = bus.reprogram || (next_state != state);

  always_ff @(posedge clk or negedge reset_global) begin
    if (!reset_global) begin
      state        <= INIT;
      start_q      <= 1'b0;
      walk_pending <= 1'b0;
      grn2_ext     <= 1'b0;
    end else begin
      state   <= next_state;
      start_q <= enter;
      if (enter && next_state == MAIN_GRN2)
        grn2_ext <= bus.sensor;
      if (bus.reprogram || (enter && next_state == WALK))
        walk_pending <= 1'b0;
      else if (bus.walk_request && state != WALK)
        walk_pending <= 1'b1;
    end
  end

  assign bus.start_timer = start_q;

  always_comb begin
    bus.interval_sel = T_BASE;
    bus.main_light   = RED;
    bus.side_light   = RED;
    bus.walk_light   = 1'b0;
    case (state)
      MAIN_GRN1: begin
        bus.main_light = GREEN;
      end
      MAIN_GRN2: begin
        bus.interval_sel = grn2_ext ? T_EXT : T_BASE;
        bus.main_light   = GREEN;
      end
      MAIN_YEL: begin
        bus.interval_sel = T_YEL;
        bus.main_light   = YELLOW;
      end
      WALK: begin
        bus.interval_sel = T_EXT;
        bus.walk_light   = 1'b1;
      end
      SIDE_GRN: begin
        bus.side_light = GREEN;
      end
      SIDE_EXT: begin
        bus.interval_sel = T_EXT;
        bus.side_light   = GREEN;
      end
      SIDE_YEL: begin
        bus.interval_sel = T_YEL;
        bus.side_light   = YELLOW;
      end
      default: begin
        bus.interval_sel = T_BASE;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_fsm.sv
// Scoreboard bench for traffic_fsm: stimulus queues the expected state outputs
// for each start_timer pulse; a negedge monitor pops and compares.
module tb_traffic_fsm;

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
  } exp_t;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  localparam exp_t E_GRN1   = '{sel: 2'b00, main: G, side: R, walk: 1'b0};
  localparam exp_t E_GRN2_B = '{sel: 2'b00, main: G, side: R, walk: 1'b0};
  localparam exp_t E_GRN2_X = '{sel: 2'b01, main: G, side: R, walk: 1'b0};
  localparam exp_t E_MYEL   = '{sel: 2'b10, main: Y, side: R, walk: 1'b0};
  localparam exp_t E_WALK   = '{sel: 2'b01, main: R, side: R, walk: 1'b1};
  localparam exp_t E_SGRN   = '{sel: 2'b00, main: R, side: G, walk: 1'b0};
  localparam exp_t E_SEXT   = '{sel: 2'b01, main: R, side: G, walk: 1'b0};
  localparam exp_t E_SYEL   = '{sel: 2'b10, main: R, side: Y, walk: 1'b0};

  logic clk = 1'b0;
  logic reset_global;

  traffic_fsm_if bus ();

  traffic_fsm dut (
    .clk          (clk),
    .reset_global (reset_global),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   pulses = 0;
  int   pushes = 0;
  exp_t cur;
  logic cur_valid = 1'b0;
  logic prev_pulse = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.sel  = bus.interval_sel;
    o.main = bus.main_light;
    o.side = bus.side_light;
    o.walk = bus.walk_light;
    return o;
  endfunction

  always @(negedge clk) begin
    if (!reset_global) begin
      cur_valid  = 1'b0;
      prev_pulse = 1'b0;
    end else begin
      chk("onehot", {6'd0, 1'b0, $onehot(bus.main_light), 7'd0, $onehot(bus.side_light)}, 16'h0101);
      if (bus.start_timer) begin
        pulses++;
        if (prev_pulse) chk("single_cycle_pulse", 16'd1, 16'd0);
        if (q.size() == 0) begin
          chk("unexpected_pulse", 16'(observed()), 16'hffff);
        end else begin
          cur = q.pop_front();
          chk("entry_outputs", 16'(observed()), 16'(cur));
          cur_valid = 1'b1;
        end
      end else if (cur_valid) begin
        chk("hold_outputs", 16'(observed()), 16'(cur));
      end
      prev_pulse = bus.start_timer;
    end
  end

  task automatic expect_entry(input exp_t e);
    q.push_back(e);
    pushes++;
  endtask

  // Drives expired for hold cycles (decision inputs alongside) after a short idle gap.
  task automatic step(input exp_t e, input logic sens, input logic wreq, input int hold);
    repeat (2) @(posedge clk);
    #1;
    bus.expired      = 1'b1;
    bus.sensor       = sens;
    bus.walk_request = wreq;
    expect_entry(e);
    repeat (hold) @(posedge clk);
    #1;
    bus.expired      = 1'b0;
    bus.sensor       = 1'b0;
    bus.walk_request = 1'b0;
  endtask

  task automatic do_reprogram(input logic with_exp);
    repeat (2) @(posedge clk);
    #1;
    bus.reprogram = 1'b1;
    bus.expired   = with_exp;
    expect_entry(E_GRN1);
    @(posedge clk);
    #1;
    bus.reprogram = 1'b0;
    bus.expired   = 1'b0;
  endtask

  task automatic pulse_walk();
    @(posedge clk);
    #1 bus.walk_request = 1'b1;
    @(posedge clk);
    #1 bus.walk_request = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_global     = 1'b0;
    bus.reprogram    = 1'b0;
    bus.sensor       = 1'b0;
    bus.walk_request = 1'b0;
    bus.expired      = 1'b0;
    #2;
    chk("reset_outputs",
        {6'd0, bus.start_timer, bus.interval_sel, bus.main_light, bus.side_light, bus.walk_light},
        {6'd0, 1'b0, 2'b00, R, R, 1'b0});

    // Reset release: INIT then MAIN_GRN1 with a pulse.
    repeat (2) @(posedge clk);
    #1;
    chk("init_before_edge", {13'd0, bus.main_light}, {13'd0, R});
    expect_entry(E_GRN1);
    reset_global = 1'b1;

    // Full cycle, no sensor, no walk.
    step(E_GRN2_B, 1'b0, 1'b0, 1);
    step(E_MYEL,   1'b0, 1'b0, 1);
    step(E_SGRN,   1'b0, 1'b0, 1);
    step(E_SYEL,   1'b0, 1'b0, 1);
    step(E_GRN1,   1'b0, 1'b0, 1);
    repeat (2) @(posedge clk);
    chk("six_pulses", 16'(pulses), 16'd6);

    // Sensor-driven extensions; sensor drops right after entry.
    step(E_GRN2_X, 1'b1, 1'b0, 1);
    repeat (3) @(posedge clk);
    #1 chk("grn2_sel_latched", {14'd0, bus.interval_sel}, 16'h0001);
    step(E_MYEL,   1'b0, 1'b0, 1);
    step(E_SGRN,   1'b0, 1'b0, 1);
    step(E_SEXT,   1'b1, 1'b0, 1);
    step(E_SYEL,   1'b0, 1'b0, 1);
    step(E_GRN1,   1'b0, 1'b0, 1);

    // Latched walk request, then a request during WALK is discarded.
    pulse_walk();
    step(E_GRN2_B, 1'b0, 1'b0, 1);
    step(E_MYEL,   1'b0, 1'b0, 1);
    step(E_WALK,   1'b0, 1'b0, 1);
    pulse_walk();
    step(E_SGRN,   1'b0, 1'b0, 1);
    step(E_SYEL,   1'b0, 1'b0, 1);
    step(E_GRN1,   1'b0, 1'b0, 1);
    step(E_GRN2_B, 1'b0, 1'b0, 1);
    step(E_MYEL,   1'b0, 1'b0, 1);
    step(E_SGRN,   1'b0, 1'b0, 1);
    step(E_SYEL,   1'b0, 1'b0, 1);
    step(E_GRN1,   1'b0, 1'b0, 1);

    // Walk request coincident with MAIN_YEL expiry.
    step(E_GRN2_B, 1'b0, 1'b0, 1);
    step(E_MYEL,   1'b0, 1'b0, 1);
    step(E_WALK,   1'b0, 1'b1, 1);
    step(E_SGRN,   1'b0, 1'b0, 1);
    step(E_SYEL,   1'b0, 1'b0, 1);

    // reprogram with expired in SIDE_YEL, then in MAIN_GRN1, then clearing a pending walk.
    do_reprogram(1'b1);
    do_reprogram(1'b0);
    pulse_walk();
    step(E_GRN2_B, 1'b0, 1'b0, 1);
    do_reprogram(1'b1);
    step(E_GRN2_B, 1'b0, 1'b0, 1);
    step(E_MYEL,   1'b0, 1'b0, 1);
    step(E_SGRN,   1'b0, 1'b0, 1);

    // expired held into the start_timer cycle must not advance twice.
    step(E_SYEL,   1'b0, 1'b0, 2);
    step(E_GRN1,   1'b0, 1'b0, 1);
    step(E_GRN2_B, 1'b0, 1'b0, 1);
    step(E_MYEL,   1'b0, 1'b0, 1);

    // Asynchronous reset mid-MAIN_YEL, no clock edge needed.
    repeat (2) @(posedge clk);
    #3 reset_global = 1'b0;
    #1;
    chk("async_reset_outputs",
        {6'd0, bus.start_timer, bus.interval_sel, bus.main_light, bus.side_light, bus.walk_light},
        {6'd0, 1'b0, 2'b00, R, R, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    bus.expired  = 1'b1;
    expect_entry(E_GRN1);
    reset_global = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.expired = 1'b0;
    step(E_GRN2_B, 1'b0, 1'b0, 1);

    repeat (5) @(posedge clk);
    chk("queue_empty", 16'(q.size()), 16'd0);
    chk("pulse_total", 16'(pulses), 16'(pushes));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
